// File: rtl/rx_state_machine.sv
// UART receive control FSM: detects and mid-bit confirms a start bit, then enables the RX counters until Done.
// Define RXSM_SYNC_EN to pass Rx through a SYNC_STAGES-deep synchronizer (adds SYNC_STAGES clk of Rx latency).
module rx_state_machine
`ifdef RXSM_SYNC_EN
  #(
    parameter int SYNC_STAGES = 2
  )
`endif
  (
    input  logic clk,
    input  logic reset,
    input  logic Rx,
    input  logic Btu,
    input  logic Done,
    output logic DoIt,
    output logic Start
  );

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] START = 2'b01;
  localparam logic [1:0] DATA  = 2'b10;

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic       w_rx;

`ifdef RXSM_SYNC_EN
  logic [SYNC_STAGES-1:0] r_rx_sync;

  // Stages reset to the idle line level so a reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_sync <= '1;
    end else begin
      r_rx_sync <= {r_rx_sync[SYNC_STAGES-2:0], Rx};
    end
  end

  assign w_rx = r_rx_sync[SYNC_STAGES-1];
`else
  assign w_rx = Rx;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (!w_rx) begin
          w_state_nxt = START;
        end
      end
      START: begin
        // A line back at 1 is a glitch, even if the half-bit strobe lands on the same edge.
        if (w_rx) begin
          w_state_nxt = IDLE;
        end else if (Btu) begin
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (Done) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign Start = (r_state == START);
  assign DoIt  = (r_state == START) || (r_state == DATA);

endmodule

// File: tb/tb_rx_state_machine.sv
// Directed bench for rx_state_machine (default build, Rx sampled directly): stimulus queues expected outputs, a monitor checks them.
module tb_rx_state_machine;

  logic clk;
  logic reset;
  logic Rx;
  logic Btu;
  logic Done;
  logic DoIt;
  logic Start;

  typedef struct {
    string tag;
    logic  s;
    logic  d;
  } exp_t;

  exp_t exp_q[$];
  int   total;
  int   bad;

  rx_state_machine dut (
    .clk   (clk),
    .reset (reset),
    .Rx    (Rx),
    .Btu   (Btu),
    .Done  (Done),
    .DoIt  (DoIt),
    .Start (Start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs for the coming edge and record the outputs expected just after it.
  task automatic step(input string tag, input logic rst, input logic rx, input logic btu,
                      input logic done, input logic es, input logic ed);
    exp_t e;
    @(negedge clk);
    reset = rst;
    Rx    = rx;
    Btu   = btu;
    Done  = done;
    e.tag = tag;
    e.s   = es;
    e.d   = ed;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are presented every cycle, checked shortly after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (Start !== e.s || DoIt !== e.d) begin
          bad++;
          $display("FAIL %s #%0d: Start,DoIt got %b,%b want %b,%b", e.tag, total, Start, DoIt, e.s, e.d);
        end
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    Rx    = 1'b1;
    Btu   = 1'b0;
    Done  = 1'b0;

    // Reset held with the line low: outputs stay 0, START taken on the first free edge.
    step("reset0", 1, 0, 0, 0, 0, 0);
    step("reset1", 1, 0, 0, 0, 0, 0);
    step("rst_rel_start", 0, 0, 0, 0, 1, 1);
    step("rst_rel_back_idle", 0, 1, 0, 0, 0, 0);

    // Idle hold: Btu and Done ignored while the line is high.
    for (int i = 0; i < 20; i++) begin
      step("idle_hold", 0, 1, (i % 3 == 0), 1, 0, 0);
    end
    step("idle_done_low", 0, 1, 0, 0, 0, 0);

    // Valid frame: start verify for clk 1..7, Btu at clk 8, Done at clk 100.
    for (int i = 1; i <= 7; i++) begin
      step("frame_start", 0, 0, 0, 0, 1, 1);
    end
    step("frame_btu", 0, 0, 1, 0, 0, 1);
    for (int i = 9; i <= 99; i++) begin
      step("frame_data", 0, i[0], (i % 16 == 0), 0, 0, 1);
    end
    step("frame_done", 0, 1, 0, 1, 0, 0);
    step("frame_idle", 0, 1, 1, 0, 0, 0);

    // False start: three low samples then the line recovers before any Btu.
    for (int i = 0; i < 3; i++) begin
      step("false_low", 0, 0, 0, 0, 1, 1);
    end
    step("false_abort", 0, 1, 0, 0, 0, 0);
    step("false_no_data", 0, 1, 1, 0, 0, 0);
    step("false_no_data2", 0, 1, 0, 1, 0, 0);

    // START: Rx=1 beats Btu.
    step("sim_start_enter", 0, 0, 0, 0, 1, 1);
    step("sim_rx_btu", 0, 1, 1, 0, 0, 0);
    step("sim_rx_btu_idle", 0, 1, 0, 0, 0, 0);

    // DATA: Done beats Btu.
    step("sim_data_start", 0, 0, 0, 0, 1, 1);
    step("sim_data_enter", 0, 0, 1, 0, 0, 1);
    step("sim_data_hold", 0, 1, 1, 0, 0, 1);
    step("sim_done_btu", 0, 0, 1, 1, 0, 0);

    // Back-to-back: Rx low on the DATA->IDLE edge is ignored, accepted on the next one.
    step("b2b_idle_start", 0, 0, 0, 0, 1, 1);
    step("b2b_data", 0, 0, 1, 0, 0, 1);
    step("b2b_done_rx0", 0, 0, 0, 1, 0, 0);
    step("b2b_new_start", 0, 0, 0, 0, 1, 1);
    step("b2b_new_data", 0, 0, 1, 0, 0, 1);

    // Reset mid-frame.
    step("rst_in_data", 1, 0, 1, 0, 0, 0);
    step("rst_after_data", 0, 1, 0, 0, 0, 0);
    step("rst_after_data2", 0, 1, 1, 1, 0, 0);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(posedge clk);
    end
    #2;
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain: pending got %0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
